div_arbiter: RTL and testbench
==============================

// Module: div_arbiter
// PURPOSE
//  Shares one iterative 64-cycle divider (div) among NUM_REQ requesters, e.g. integer pipe and a second issue slot.
//  Round-robin grant, valid/ready on request and response sides, and per-requester flush (kill) of in-flight ops.
//  Drives the divider's en/operands/op, collects its result and returns it to the granted requester.
//  Owns the divider's handshake: the divider is never re-armed with stale operands.
// PARAMETERS
//  NUM_REQ  2  number of requesters (1..8); GW = $clog2(NUM_REQ) (min 1) is the grant-index width
// PORTS
//  clock          in   1            system clock
//  reset          in   1            synchronous, active-high reset
//  req_valid      in   NUM_REQ      requester i has an op pending
//  req_ready      out  NUM_REQ      one-hot accept pulse; req_valid&req_ready = op taken
//  req_in1        in   NUM_REQ*64   dividend per requester, slice [64*i+:64]
//  req_in2        in   NUM_REQ*64   divisor per requester
//  req_word       in   NUM_REQ      1 = 32-bit (divw/remw) op
//  req_op         in   div_op[NUM_REQ]  DIV/DIVU/REM/REMU, div_op enum from def.svh
//  flush          in   NUM_REQ      kill requester i's pending/in-flight op
//  rsp_valid      out  NUM_REQ      one-hot: result ready for requester i
//  rsp_ready      in   NUM_REQ      requester i consumes result
//  rsp_data       out  64           result, valid only while some rsp_valid bit is set
//  div_en         out  1            divider enable; low resets the divider
//  div_in1        out  64           latched dividend
//  div_in2        out  64           latched divisor
//  div_word       out  1            latched word flag
//  div_op         out  div_op       latched op
//  div_out        in   64           divider result
//  div_out_valid  in   1            divider in FINAL
//  div_out_ready  out  1            result-consume strobe to divider
//  busy           out  1            state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, operand/result regs=0; all outputs 0 (div_en=0, req_ready=0, rsp_valid=0).
//  States IDLE -> BUSY -> RESP -> IDLE.
//  IDLE: div_en=0.
//   - Eligible = req_valid & ~flush.
//   - Grant = first eligible index starting at rr_ptr, wrapping.
//   - If any eligible: req_ready[g]=1 this cycle; latch in1/in2/word/op and g; next state BUSY.
//   - If none eligible: stay IDLE.
//  BUSY: div_en=1; div_* driven from latches only, stable for the whole op.
//   - div_out_ready = div_out_valid.
//   - On div_out_valid: capture div_out into result reg; next state RESP.
//  RESP: div_en=0 (returns divider to IDLE, no re-start).
//   - rsp_valid[g]=1; rsp_data=result reg.
//   - On rsp_ready[g]: next state IDLE, rr_ptr <= (g+1) mod NUM_REQ.
//  Flush:
//   - flush[g] in BUSY: abandon op; next IDLE (div_en low there resets divider); rr_ptr advances past g; no response.
//   - flush[g] in RESP: drop the result; next IDLE; rr_ptr advances; rsp_valid not asserted that cycle.
//   - flush of a non-granted requester: only masks its eligibility.
//   - flush[g] and rsp_ready[g] in the same cycle: flush wins, no handshake.
//  Latency (accept at cycle T):
//   - Normal op: BUSY from T+1, div_out_valid at T+66, rsp_valid at T+67.
//   - Divisor==0 or signed overflow (-2^(L-1) / -1): div_out_valid at T+2, rsp_valid at T+3.
//  Throughput: at most one op in flight; the next grant is no earlier than the cycle after the response handshake.
//  No arithmetic here; operands pass unmodified (sign handling lives in the divider).
//  Unused requester inputs (req_in*, req_word, req_op) are don't-care when req_valid=0.
//  Reset mid-op: immediate return to IDLE, result lost, div_en low next cycle.
// TESTING
//  - Single op: req0 DIV in1=100 in2=7 -> req_ready[0] at T, rsp_valid[0] at T+67, rsp_data=14.
//  - Fairness: req0, req1 held valid continuously -> grants alternate 0,1,0,1; results match each requester's operands.
//  - Special cases: DIVU by 0, in1=5 -> rsp_data=64'hFFFF_FFFF_FFFF_FFFF at T+3; REMW in1=32'h8000_0000 in2=-1 -> rsp_data=0 at T+3.
//  - Flush in BUSY: flush[1] at T+20 -> no rsp_valid; div_en low at T+21; next grant to req0 at T+21 with a correct result.
//  - Backpressure: rsp_ready held low 10 cycles -> rsp_valid/rsp_data stable; div_en=0 throughout; no new grant.
//  - Reset at T+30 of an op -> all outputs 0 next cycle; new op after reset returns the correct result.

Source files
------------

// File: rtl/div_arbiter.sv
// Round-robin front end that shares one iterative 64-bit divider among NUM_REQ
// requesters, with valid/ready on both sides and per-requester kill.
package div_pkg;
  typedef enum logic [1:0] {DIV = 2'd0, DIVU = 2'd1, REM = 2'd2, REMU = 2'd3} div_op_e;
endpackage

module div_arbiter
  import div_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int GW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*64-1:0]   req_in1,
  input  logic [NUM_REQ*64-1:0]   req_in2,
  input  logic [NUM_REQ-1:0]      req_word,
  input  div_op_e [NUM_REQ-1:0]   req_op,
  input  logic [NUM_REQ-1:0]      flush,
  output logic [NUM_REQ-1:0]      rsp_valid,
  input  logic [NUM_REQ-1:0]      rsp_ready,
  output logic [63:0]             rsp_data,
  output logic                    div_en,
  output logic [63:0]             div_in1,
  output logic [63:0]             div_in2,
  output logic                    div_word,
  output div_op_e                 div_op,
  input  logic [63:0]             div_out,
  input  logic                    div_out_valid,
  output logic                    div_out_ready,
  output logic                    busy
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e             state, state_nxt;
  logic [GW-1:0]      rr_ptr, gnt, grant_idx, gnt_inc;
  logic [NUM_REQ-1:0] elig;
  logic               grant_found;
  logic [63:0]        result;

  assign elig    = req_valid & ~flush;
  assign gnt_inc = (int'(gnt) == NUM_REQ - 1) ? '0 : gnt + 1'b1;
  assign busy    = (state != IDLE);
  assign rsp_data = result;

  // First eligible requester at or after rr_ptr, wrapping.
  always_comb begin : rr_sel
    int j;
    j           = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(rr_ptr) + k) % NUM_REQ;
      if (!grant_found && elig[j]) begin
        grant_found = 1'b1;
        grant_idx   = GW'(j);
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    req_ready     = '0;
    rsp_valid     = '0;
    div_en        = 1'b0;
    div_out_ready = 1'b0;
    unique case (state)
      IDLE: if (grant_found) begin
        req_ready[grant_idx] = !reset;
        state_nxt            = BUSY;
      end
      BUSY: begin
        div_en        = 1'b1;
        div_out_ready = div_out_valid;
        // A kill drops div_en next cycle, which also clears the divider.
        if (flush[gnt])         state_nxt = IDLE;
        else if (div_out_valid) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid[gnt] = !flush[gnt];
        if (flush[gnt] || rsp_ready[gnt]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      gnt      <= '0;
      div_in1  <= '0;
      div_in2  <= '0;
      div_word <= 1'b0;
      div_op   <= DIV;
      result   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && grant_found) begin
        gnt      <= grant_idx;
        div_in1  <= req_in1[64*grant_idx +: 64];
        div_in2  <= req_in2[64*grant_idx +: 64];
        div_word <= req_word[grant_idx];
        div_op   <= req_op[grant_idx];
      end
      if (state == BUSY && div_out_valid) result <= div_out;
      // Completion or kill both hand priority to the next requester.
      if (state != IDLE && state_nxt == IDLE) rr_ptr <= gnt_inc;
    end
  end
endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter with a behavioural 64-cycle divider attached.
module tb_div_arbiter;
  import div_pkg::*;

  logic           clock = 1'b0;
  logic           reset;
  logic [1:0]     req_valid, req_ready, req_word, flush, rsp_valid, rsp_ready;
  logic [127:0]   req_in1, req_in2;
  div_op_e [1:0]  req_op;
  logic [63:0]    rsp_data, div_in1, div_in2, div_out;
  logic           div_en, div_word, div_out_valid, div_out_ready, busy;
  div_op_e        div_op;

  div_arbiter #(.NUM_REQ(2)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_in1(req_in1), .req_in2(req_in2), .req_word(req_word), .req_op(req_op),
    .flush(flush), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .div_en(div_en), .div_in1(div_in1), .div_in2(div_in2), .div_word(div_word),
    .div_op(div_op), .div_out(div_out), .div_out_valid(div_out_valid),
    .div_out_ready(div_out_ready), .busy(busy)
  );

  always #5 clock = ~clock;

  // Divider model: returns {fast, result}; fast = divide by zero or signed overflow.
  function automatic logic [64:0] div_ref(input div_op_e op, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
    logic signed [63:0] sa, sb;
    logic [63:0] ua, ub, r;
    logic sgn, ovf;
    sgn = (op == DIV || op == REM);
    if (w) begin
      sa = {{32{a[31]}}, a[31:0]}; sb = {{32{b[31]}}, b[31:0]};
      ua = {32'b0, a[31:0]};       ub = {32'b0, b[31:0]};
    end else begin
      sa = a; sb = b; ua = a; ub = b;
    end
    ovf = sgn && (sb == -64'sd1) &&
          (w ? (sa == 64'hFFFF_FFFF_8000_0000) : (sa == 64'h8000_0000_0000_0000));
    r = '0;
    case (op)
      DIV:  if (ub == 0) r = '1; else if (ovf) r = sa; else r = sa / sb;
      DIVU: if (ub == 0) r = '1; else r = ua / ub;
      REM:  if (ub == 0) r = sa; else if (ovf) r = '0; else r = sa % sb;
      REMU: if (ub == 0) r = ua; else r = ua % ub;
      default: r = '0;
    endcase
    if (w) r = {{32{r[31]}}, r[31:0]};
    return {(ub == 0) || ovf, r};
  endfunction

  logic [6:0]   dcnt = '0;
  logic [63:0]  m_res = '0;
  logic         m_fast = 1'b0, op_unstable = 1'b0, hs_bad = 1'b0;
  logic [130:0] m_ops = '0;

  assign div_out_valid = div_en && (m_fast ? (dcnt >= 7'd1) : (dcnt >= 7'd65));
  assign div_out       = m_res;

  always @(posedge clock) begin
    if (!div_en) dcnt <= '0;
    else if (dcnt != 7'd127) dcnt <= dcnt + 7'd1;
    if (div_en && dcnt == 0) begin
      {m_fast, m_res} <= div_ref(div_op, div_word, div_in1, div_in2);
      m_ops <= {div_in1, div_in2, div_word, div_op};
    end
    if (div_en && dcnt != 0 && m_ops != {div_in1, div_in2, div_word, div_op}) op_unstable <= 1'b1;
    if (div_en && (div_out_valid !== div_out_ready)) hs_bad <= 1'b1;
  end

  int nvec = 0, nerr = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock); #1;
  endtask

  // Drives an op, waits (bounded) for its accept, then scrambles the inputs at T+1.
  task automatic issue(input int r, input div_op_e op, input logic w,
                       input logic [63:0] a, input logic [63:0] b);
    int n;
    n = 0;
    req_valid[r] = 1'b1; req_in1[64*r +: 64] = a; req_in2[64*r +: 64] = b;
    req_word[r] = w; req_op[r] = op;
    #1;
    while (!req_ready[r] && n < 200) begin step(); n++; end
    check($sformatf("grant_req%0d", r), 64'(req_ready[r]), 64'd1);
    step();
    req_valid[r] = 1'b0; req_in1[64*r +: 64] = 64'hDEAD_BEEF_0BAD_F00D;
    req_in2[64*r +: 64] = 64'd3; req_word[r] = ~w; req_op[r] = REMU;
  endtask

  task automatic wait_rsp(input int r, output int lat);
    lat = 1;
    while (!rsp_valid[r] && lat < 200) begin step(); lat++; end
  endtask

  task automatic handshake(input int r);
    rsp_ready[r] = 1'b1; step(); rsp_ready[r] = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; req_valid = '0; flush = '0; rsp_ready = '0;
    step(); step();
    reset = 1'b0;
  endtask

  typedef struct {
    int r; div_op_e op; logic w; logic [63:0] a, b, exp; int lat;
  } vec_t;
  vec_t vt[10];

  initial begin
    int lat, n, bad;
    vt[0] = '{0, DIV,  1'b0, 64'd100, 64'd7, 64'd14, 67};
    vt[1] = '{1, DIVU, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 3};
    vt[2] = '{0, REM,  1'b1, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 3};
    vt[3] = '{1, REM,  1'b0, 64'd100, 64'd7, 64'd2, 67};
    vt[4] = '{0, DIV,  1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 67};
    vt[5] = '{1, DIV,  1'b1, 64'h0000_0001_FFFF_FFF6, 64'd3, 64'hFFFF_FFFF_FFFF_FFFD, 67};
    vt[6] = '{0, REMU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd10, 64'd5, 67};
    vt[7] = '{1, DIV,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
              64'h8000_0000_0000_0000, 3};
    vt[8] = '{0, REM,  1'b0, 64'd42, 64'd0, 64'd42, 3};
    vt[9] = '{1, DIVU, 1'b1, 64'hFFFF_FFFF_0000_0010, 64'h1234_5678_0000_0004, 64'd4, 67};

    req_in1 = '0; req_in2 = '0; req_word = '0; req_op = {DIV, DIV};
    reset = 1'b1; req_valid = '0; flush = '0; rsp_ready = '0;
    step(); step();
    check("reset_ctrl", 64'({req_ready, rsp_valid, div_en, div_out_ready, busy}), 64'd0);
    check("reset_rsp_data", rsp_data, 64'd0);
    check("reset_div_ops", 64'({div_in1 | div_in2, div_word, div_op}), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      issue(vt[i].r, vt[i].op, vt[i].w, vt[i].a, vt[i].b);
      wait_rsp(vt[i].r, lat);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vt[i].lat));
      check($sformatf("vec%0d_data", i), rsp_data, vt[i].exp);
      handshake(vt[i].r);
    end

    // Fairness: both requesters held valid, responses consumed at once.
    do_reset();
    rsp_ready = 2'b11; req_valid = 2'b11; req_word = '0; req_op = {DIVU, DIVU};
    req_in1 = {64'd81, 64'd1000}; req_in2 = {64'd9, 64'd10};
    #1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (req_ready == 2'b00 && n < 300) begin step(); n++; end
      check($sformatf("fair_grant%0d", k), 64'(req_ready), (k % 2) ? 64'd2 : 64'd1);
      n = 0;
      while (rsp_valid == 2'b00 && n < 300) begin step(); n++; end
      check($sformatf("fair_rsp%0d", k), 64'(rsp_valid), (k % 2) ? 64'd2 : 64'd1);
      check($sformatf("fair_data%0d", k), rsp_data, (k % 2) ? 64'd9 : 64'd100);
      step();
    end
    req_valid = '0; rsp_ready = '0;

    // Flush and rsp_ready together in RESP: the kill wins.
    issue(0, DIVU, 1'b0, 64'd5, 64'd0);
    wait_rsp(0, lat);
    flush[0] = 1'b1; rsp_ready[0] = 1'b1; #1;
    check("flush_masks_rsp", 64'(rsp_valid), 64'd0);
    step(); flush = '0; rsp_ready = '0;
    check("flush_resp_idle", 64'({busy, rsp_valid}), 64'd0);

    // Backpressure on a ready response with another requester waiting.
    issue(0, DIVU, 1'b0, 64'd5, 64'd0);
    wait_rsp(0, lat);
    check("bp_latency", 64'(lat), 64'd3);
    req_valid[1] = 1'b1; req_in1[127:64] = 64'd17; req_in2[127:64] = 64'd5;
    req_word[1] = 1'b0; req_op[1] = REMU;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (rsp_valid != 2'b01 || rsp_data != 64'hFFFF_FFFF_FFFF_FFFF || div_en || req_ready != 2'b00)
        bad++;
    end
    check("bp_stable", 64'(bad), 64'd0);
    handshake(0);
    check("bp_next_grant", 64'(req_ready), 64'd2);
    step(); req_valid[1] = 1'b0;
    wait_rsp(1, lat);
    check("bp_req1_latency", 64'(lat), 64'd67);
    check("bp_req1_data", rsp_data, 64'd2);
    handshake(1);

    // Kill requester 1 at T+20; requester 0 is served at T+21.
    do_reset();
    issue(1, DIV, 1'b0, 64'd100, 64'd7);
    bad = 0;
    for (int k = 2; k <= 20; k++) begin step(); if (rsp_valid != 2'b00) bad++; end
    flush[1] = 1'b1; req_valid[0] = 1'b1; req_in1[63:0] = 64'd50; req_in2[63:0] = 64'd5;
    req_word[0] = 1'b0; req_op[0] = DIV;
    step(); flush = '0; #1;
    check("flush_busy_no_rsp", 64'(bad), 64'd0);
    check("flush_busy_div_en", 64'(div_en), 64'd0);
    check("flush_busy_regrant", 64'(req_ready), 64'd1);
    step(); req_valid[0] = 1'b0;
    wait_rsp(0, lat);
    check("flush_busy_rsp", 64'(rsp_valid), 64'd1);
    check("flush_busy_data", rsp_data, 64'd10);
    handshake(0);

    // Reset in the middle of an op.
    issue(0, DIV, 1'b0, 64'd100, 64'd7);
    for (int k = 2; k <= 30; k++) step();
    reset = 1'b1;
    step();
    check("midreset_ctrl", 64'({req_ready, rsp_valid, div_en, div_out_ready, busy}), 64'd0);
    check("midreset_data", rsp_data, 64'd0);
    reset = 1'b0;
    issue(1, DIV, 1'b0, 64'd63, 64'd9);
    wait_rsp(1, lat);
    check("postreset_latency", 64'(lat), 64'd67);
    check("postreset_data", rsp_data, 64'd7);
    handshake(1);

    check("div_operands_stable", 64'(op_unstable), 64'd0);
    check("div_out_ready_strobe", 64'(hs_bad), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
